trapez_peak_detector: RTL and testbench
=======================================

# trapez_peak_detector

Pulse-height analyzer directly downstream of `trapez_shaper`; consumes its `output_data`/`output_data_valid` stream. Detects each trapezoid by threshold crossing, averages a window on the flat top, and emits one amplitude word plus a crossing timestamp per accepted event. Rejects pulses too short to have a measurable flat top and flags pile-up, i.e. trapezoids longer than the allowed maximum.

## Interface
- `DATA_WIDTH`, 16, width of signed shaper samples
- `TS_WIDTH`, 32, timestamp counter width
- `THRESHOLD`, 100, signed trigger level; a sample is "high" when strictly greater than it
- `FLAT_TOP_DELAY`, 4, valid samples from the crossing to the first averaged sample (≥1)
- `AVG_LEN`, 4, number of averaged samples; power of two, 1..16
- `MAX_PULSE_LEN`, 32, valid high samples from the crossing before the event counts as pile-up; must be > `FLAT_TOP_DELAY + AVG_LEN`
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `input_data`  in  DATA_WIDTH  signed shaped sample, from `trapez_shaper.output_data`
- `input_data_valid`  in  1  sample qualifier, from `trapez_shaper.output_data_valid`
- `peak_data`  out  DATA_WIDTH  signed averaged flat-top amplitude
- `peak_timestamp`  out  TS_WIDTH  timestamp latched at the crossing sample
- `peak_data_valid`  out  1  one-cycle strobe qualifying `peak_data` and `peak_timestamp`
- `peak_pileup`  out  1  pile-up flag qualified by `peak_data_valid`; present only with `TRAPEZ_PEAK_PILEUP_FLAG_EN`

## Operation
- Free-running `ts` counter increments every `clk` edge, independent of valid, and wraps modulo 2^TS_WIDTH.
- Only cycles with `input_data_valid`=1 advance the FSM or any counter. Invalid cycles hold all state.
- Sample index k counts valid samples since the crossing; the crossing sample is k=0.
- FSM states and transitions:
  - IDLE: on a high sample, latch `ts`, clear the accumulator, set k=0, and go to DELAY.
  - DELAY: if a sample is not high, discard the event and go to IDLE. When k reaches `FLAT_TOP_DELAY`, go to ACCUM and add the current sample.
  - ACCUM: add samples k = `FLAT_TOP_DELAY` .. `FLAT_TOP_DELAY+AVG_LEN-1`. A sample that is not high in this range discards the event and returns to IDLE. After the last add, go to WAIT_FALL.
  - WAIT_FALL: set the pileup flag when k reaches `MAX_PULSE_LEN` while still high. On the first sample that is not high, go to EMIT.
  - EMIT: present the result for one cycle, then go to IDLE. A high sample arriving in EMIT is not a crossing; the detector re-arms only from IDLE.
- Accumulator width is `DATA_WIDTH + log2(AVG_LEN)`, signed. `peak_data` = accumulator arithmetic-shifted right by `log2(AVG_LEN)`, which floors the average.
- The k counter saturates at `MAX_PULSE_LEN`, so there is no wrap on very long pulses.

## Timing
- Reset values: `peak_data`=0, `peak_timestamp`=0, `peak_data_valid`=0, `peak_pileup`=0, `ts`=0, FSM=IDLE.
- `peak_data_valid` rises on the clock edge after the falling (not-high) sample is accepted, and stays high for exactly one cycle.
- `peak_data`/`peak_timestamp` are registered and hold their value until the next emit.
- `peak_timestamp` equals the `ts` value in the cycle the crossing sample was accepted.
- Reset asserted mid-event aborts the event: no strobe, and all outputs clear immediately.
- Minimum event-to-event spacing is one idle valid sample after EMIT.

## Configuration
- `TRAPEZ_PEAK_PILEUP_FLAG_EN` defined: the `peak_pileup` port exists, and pile-up events are emitted with `peak_pileup`=1.
- `TRAPEZ_PEAK_PILEUP_FLAG_EN` undefined: the port is absent, and pile-up events are silently dropped (no strobe). All other events are unchanged.

## Structure
- `settings_pkg`: `DATA_WIDTH`/`TS_WIDTH` defaults, the FSM state enum `trapez_peak_state_t`, and the `clog2`-derived accumulator width constant.
- `interfaces_pkg`: add `trapez_peak_result_intf` carrying `peak_data`, `peak_timestamp`, `peak_data_valid`, and `peak_pileup`.
- Sub-module `trapez_peak_accumulator`: clear/add/shift averaging datapath. The FSM, k counter, and `ts` stay in the top.

## Test plan
All scenarios use `THRESHOLD`=100, `FLAT_TOP_DELAY`=4, `AVG_LEN`=4, `MAX_PULSE_LEN`=32.

- Clean trapezoid (0, 50, 150, 300, 500, 800, then 1000×10, 600, 50) -> one strobe with `peak_data`=1000, `peak_timestamp`= `ts` at the 150 sample, `peak_pileup`=0.
- Averaging with flat samples 1000, 1001, 1002, 1003 at k=4..7 -> `peak_data`=1001.
- Short pulse of 200×5, then 0 -> no strobe; the next clean pulse still measures 1000.
- Long pulse of 1000×40, then 0 -> with the macro, a strobe with `peak_data`=1000 and `peak_pileup`=1; without the macro, no strobe.
- Clean trapezoid with `input_data_valid` toggling 1/0 each cycle -> the same result as the first scenario; the timestamp reflects the real crossing cycle.
- Reset driven low at k=5 of a clean pulse -> outputs 0 immediately and no strobe; a pulse after reset is released measures normally.

Source files
------------

// File: rtl/trapez_peak_detector_pkg.sv
// Shared constants, FSM state type and width helper for the peak detector.
// Optional pile-up flag output: TRAPEZ_PEAK_PILEUP_FLAG_EN.
package trapez_peak_detector_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TS_WIDTH   = 32;
    localparam int DEF_AVG_LEN    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_ACCUM,
        ST_WAIT_FALL,
        ST_EMIT
    } trapez_peak_state_t;

    function automatic int acc_width(input int dw, input int avg);
        return dw + $clog2(avg);
    endfunction

    localparam int DEF_ACC_WIDTH = DEF_DATA_WIDTH + $clog2(DEF_AVG_LEN);

endpackage

// File: rtl/trapez_peak_detector_if.sv
// Result bundle of the peak detector; peak_pileup present only with
// TRAPEZ_PEAK_PILEUP_FLAG_EN.
interface trapez_peak_result_intf #(
    parameter int DATA_WIDTH = 16,
    parameter int TS_WIDTH   = 32
);
    logic signed [DATA_WIDTH-1:0] peak_data;
    logic [TS_WIDTH-1:0]          peak_timestamp;
    logic                         peak_data_valid;
`ifdef TRAPEZ_PEAK_PILEUP_FLAG_EN
    logic                         peak_pileup;

    modport master (
        output peak_data,
        output peak_timestamp,
        output peak_data_valid,
        output peak_pileup
    );
    modport slave (
        input peak_data,
        input peak_timestamp,
        input peak_data_valid,
        input peak_pileup
    );
`else
    modport master (
        output peak_data,
        output peak_timestamp,
        output peak_data_valid
    );
    modport slave (
        input peak_data,
        input peak_timestamp,
        input peak_data_valid
    );
`endif
endinterface

// File: rtl/trapez_peak_detector_accumulator.sv
// Flat-top averaging datapath: clear, signed add, floor-divide by shift.
// Optional feature macro of the parent: TRAPEZ_PEAK_PILEUP_FLAG_EN.
module trapez_peak_accumulator
    import trapez_peak_detector_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AVG_LEN    = DEF_AVG_LEN
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_add,
    input  logic signed [DATA_WIDTH-1:0] i_sample,
    output logic signed [DATA_WIDTH-1:0] o_avg
);

    localparam int ACC_W = acc_width(DATA_WIDTH, AVG_LEN);
    localparam int SHIFT = $clog2(AVG_LEN);

    logic signed [ACC_W-1:0] r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + ACC_W'(i_sample);
        end
    end

    // Arithmetic shift floors the average for negative sums too
    assign o_avg = DATA_WIDTH'(r_acc >>> SHIFT);

endmodule

// File: rtl/trapez_peak_detector.sv
// Trapezoid pulse-height analyzer: threshold trigger, flat-top average,
// crossing timestamp. Pile-up flag output: TRAPEZ_PEAK_PILEUP_FLAG_EN.
module trapez_peak_detector
    import trapez_peak_detector_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TS_WIDTH       = DEF_TS_WIDTH,
    parameter int THRESHOLD      = 100,
    parameter int FLAT_TOP_DELAY = 4,
    parameter int AVG_LEN        = DEF_AVG_LEN,
    parameter int MAX_PULSE_LEN  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] input_data,
    input  logic                         input_data_valid,
    trapez_peak_result_intf.master       res
);

    localparam int KW = $clog2(MAX_PULSE_LEN + 1);
    localparam logic [KW-1:0] K_FTD  = KW'(FLAT_TOP_DELAY);
    localparam logic [KW-1:0] K_LAST = KW'(FLAT_TOP_DELAY + AVG_LEN - 1);
    localparam logic [KW-1:0] K_MAX  = KW'(MAX_PULSE_LEN);
    localparam logic signed [DATA_WIDTH-1:0] THR = DATA_WIDTH'(THRESHOLD);

    trapez_peak_state_t r_state;
    trapez_peak_state_t w_state_nx;

    logic [KW-1:0]         r_k;
    logic [KW-1:0]         w_k_nx;
    logic [KW-1:0]         w_k_inc;
    logic                  r_pile;
    logic                  w_pile_nx;
    logic [TS_WIDTH-1:0]   r_ts;
    logic [TS_WIDTH-1:0]   r_cross_ts;

    logic                  w_high;
    logic                  w_latch;
    logic                  w_clear;
    logic                  w_add;
    logic                  w_fall;
    logic                  w_emit;
    logic signed [DATA_WIDTH-1:0] w_avg;

    logic signed [DATA_WIDTH-1:0] r_peak_data;
    logic [TS_WIDTH-1:0]          r_peak_ts;
    logic                         r_peak_valid;

    assign w_high  = input_data > THR;
    assign w_k_inc = (r_k == K_MAX) ? r_k : r_k + KW'(1);

    trapez_peak_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .AVG_LEN    (AVG_LEN)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_add    (w_add),
        .i_sample (input_data),
        .o_avg    (w_avg)
    );

    always_comb begin
        w_state_nx = r_state;
        w_k_nx     = r_k;
        w_pile_nx  = r_pile;
        w_latch    = 1'b0;
        w_clear    = 1'b0;
        w_add      = 1'b0;
        w_fall     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (input_data_valid && w_high) begin
                    w_latch    = 1'b1;
                    w_clear    = 1'b1;
                    w_k_nx     = '0;
                    w_pile_nx  = 1'b0;
                    w_state_nx = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (input_data_valid) begin
                    if (!w_high) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_k_nx = w_k_inc;
                        if (w_k_inc == K_FTD) begin
                            w_add      = 1'b1;
                            w_state_nx = (AVG_LEN == 1) ? ST_WAIT_FALL
                                                        : ST_ACCUM;
                        end
                    end
                end
            end
            ST_ACCUM: begin
                if (input_data_valid) begin
                    if (!w_high) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_k_nx = w_k_inc;
                        w_add  = 1'b1;
                        if (w_k_inc == K_LAST) begin
                            w_state_nx = ST_WAIT_FALL;
                        end
                    end
                end
            end
            ST_WAIT_FALL: begin
                if (input_data_valid) begin
                    if (w_high) begin
                        w_k_nx = w_k_inc;
                        if (w_k_inc == K_MAX) begin
                            w_pile_nx = 1'b1;
                        end
                    end else begin
                        w_fall     = 1'b1;
                        w_state_nx = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_pile     <= 1'b0;
            r_ts       <= '0;
            r_cross_ts <= '0;
        end else begin
            r_state <= w_state_nx;
            r_k     <= w_k_nx;
            r_pile  <= w_pile_nx;
            r_ts    <= r_ts + TS_WIDTH'(1);
            if (w_latch) begin
                r_cross_ts <= r_ts;
            end
        end
    end

`ifdef TRAPEZ_PEAK_PILEUP_FLAG_EN
    logic r_peak_pile;

    assign w_emit = w_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_peak_pile <= 1'b0;
        end else if (w_emit) begin
            r_peak_pile <= r_pile;
        end
    end

    assign res.peak_pileup = r_peak_pile;
`else
    // Pile-up events still pass through EMIT but raise no strobe
    assign w_emit = w_fall && !r_pile;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_peak_data  <= '0;
            r_peak_ts    <= '0;
            r_peak_valid <= 1'b0;
        end else begin
            r_peak_valid <= w_emit;
            if (w_emit) begin
                r_peak_data <= w_avg;
                r_peak_ts   <= r_cross_ts;
            end
        end
    end

    assign res.peak_data       = r_peak_data;
    assign res.peak_timestamp  = r_peak_ts;
    assign res.peak_data_valid = r_peak_valid;

endmodule

// File: tb/tb_trapez_peak_detector.sv
// Randomized and directed bench for trapez_peak_detector with a
// pulse-level reference model.
module tb_trapez_peak_detector;

    localparam int DW   = 16;
    localparam int TW   = 32;
    localparam int TH   = 100;
    localparam int FTD  = 4;
    localparam int AVG  = 4;
    localparam int MAXL = 32;
`ifdef TRAPEZ_PEAK_PILEUP_FLAG_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic signed [DW-1:0] input_data = '0;
    logic                 input_data_valid = 1'b0;

    trapez_peak_result_intf #(.DATA_WIDTH(DW), .TS_WIDTH(TW)) res ();

    trapez_peak_detector #(
        .DATA_WIDTH     (DW),
        .TS_WIDTH       (TW),
        .THRESHOLD      (TH),
        .FLAT_TOP_DELAY (FTD),
        .AVG_LEN        (AVG),
        .MAX_PULSE_LEN  (MAXL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .input_data       (input_data),
        .input_data_valid (input_data_valid),
        .res              (res)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Pulse-level reference: collects the run of high samples and
    // judges it when the run ends.
    int     tcnt;
    bit     in_pulse;
    bit     blank;
    int     run;
    int     buf_q[$];
    int     cross_ts;
    bit     exp_valid;
    int     exp_data;
    longint exp_ts;
    bit     exp_pile;

    always @(posedge clk or negedge reset) begin
        int  x;
        int  sum;
        bit  pile;
        if (!reset) begin
            tcnt = 0; in_pulse = 0; blank = 0; run = 0;
            buf_q = {}; cross_ts = 0;
            exp_valid = 0; exp_data = 0; exp_ts = 0; exp_pile = 0;
        end else begin
            exp_valid = 0;
            if (blank) begin
                blank = 0;
            end else if (input_data_valid) begin
                x = int'(input_data);
                if (x > TH) begin
                    if (!in_pulse) begin
                        in_pulse = 1; run = 0; buf_q = {};
                        cross_ts = tcnt;
                    end
                    run++;
                    if (buf_q.size() < FTD + AVG) buf_q.push_back(x);
                end else if (in_pulse) begin
                    in_pulse = 0;
                    if (run >= FTD + AVG) begin
                        blank = 1;
                        pile  = run > MAXL;
                        if (!pile || PEN) begin
                            sum = 0;
                            for (int i = FTD; i < FTD + AVG; i++)
                                sum += buf_q[i];
                            exp_valid = 1;
                            exp_data  = (sum - (((sum % AVG) + AVG) % AVG)) / AVG;
                            exp_ts    = cross_ts;
                            exp_pile  = pile;
                        end
                    end
                end
            end
            tcnt++;
        end
    end

    int     n_strobe = 0;
    int     cap_data;
    longint cap_ts;
    bit     cap_pile;

    always @(negedge clk) begin
        chk("valid", res.peak_data_valid, exp_valid);
        chk("data", res.peak_data, exp_data);
        chk("timestamp", res.peak_timestamp, exp_ts);
`ifdef TRAPEZ_PEAK_PILEUP_FLAG_EN
        chk("pileup", res.peak_pileup, exp_pile);
`endif
        if (res.peak_data_valid === 1'b1) begin
            n_strobe++;
            cap_data = int'(res.peak_data);
            cap_ts   = longint'(res.peak_timestamp);
`ifdef TRAPEZ_PEAK_PILEUP_FLAG_EN
            cap_pile = res.peak_pileup;
`else
            cap_pile = 1'b0;
`endif
        end
    end

    task automatic drv(input int x, input bit v);
        input_data       = DW'(x);
        input_data_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int v[18], input bit toggle, output int tc);
        tc = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 2) tc = tcnt;
            drv(v[i], 1'b1);
            if (toggle) drv(int'($urandom_range(0, 2000)), 1'b0);
        end
        repeat (3) drv(0, 1'b1);
    endtask

    task automatic expect_evt(input string nm, input int s0, input int cnt,
                              input int d, input longint t, input bit p);
        chk({nm, " strobes"}, n_strobe - s0, cnt);
        if (cnt > 0) begin
            chk({nm, " data"}, cap_data, d);
            chk({nm, " ts"}, cap_ts, t);
            chk({nm, " pile"}, cap_pile, p);
        end
    endtask

    int clean[18] = '{0, 50, 150, 300, 500, 800, 1000, 1000, 1000, 1000,
                      1000, 1000, 1000, 1000, 1000, 1000, 600, 50};
    int avgv[18]  = '{0, 50, 150, 300, 500, 800, 1000, 1001, 1002, 1003,
                      1000, 1000, 1000, 1000, 1000, 1000, 600, 50};
    int bnd[6]    = '{7, 8, 9, 32, 33, 40};

    initial begin
        int s0;
        int tc;
        int len;
        repeat (3) @(posedge clk);
        #1;
        chk("rst data", res.peak_data, 0);
        chk("rst ts", res.peak_timestamp, 0);
        chk("rst valid", res.peak_data_valid, 0);
        reset = 1'b1;

        s0 = n_strobe;
        run_seq(clean, 1'b0, tc);
        expect_evt("clean", s0, 1, 1000, 2, 1'b0);

        s0 = n_strobe;
        run_seq(avgv, 1'b0, tc);
        expect_evt("average", s0, 1, 1001, tc, 1'b0);

        s0 = n_strobe;
        repeat (5) drv(200, 1'b1);
        repeat (2) drv(0, 1'b1);
        chk("short strobes", n_strobe - s0, 0);
        s0 = n_strobe;
        run_seq(clean, 1'b0, tc);
        expect_evt("after short", s0, 1, 1000, tc, 1'b0);

        s0 = n_strobe;
        drv(0, 1'b1);
        tc = tcnt;
        repeat (40) drv(1000, 1'b1);
        repeat (3) drv(0, 1'b1);
        expect_evt("pileup", s0, PEN ? 1 : 0, 1000, tc, 1'b1);

        s0 = n_strobe;
        run_seq(clean, 1'b1, tc);
        expect_evt("toggle", s0, 1, 1000, tc, 1'b0);

        for (int i = 0; i < 8; i++) drv(clean[i], 1'b1);
        reset = 1'b0;
        #1;
        chk("mid-rst data", res.peak_data, 0);
        chk("mid-rst ts", res.peak_timestamp, 0);
        chk("mid-rst valid", res.peak_data_valid, 0);
        s0 = n_strobe;
        @(posedge clk);
        #1;
        repeat (3) drv(0, 1'b1);
        reset = 1'b1;
        chk("mid-rst strobes", n_strobe - s0, 0);
        s0 = n_strobe;
        run_seq(clean, 1'b0, tc);
        expect_evt("after rst", s0, 1, 1000, 2, 1'b0);

        for (int e = 0; e < 300; e++) begin
            repeat ($urandom_range(1, 6))
                drv(int'($urandom_range(0, 300)) - 200, 1'b1);
            if ($urandom_range(0, 3) == 0)
                len = bnd[$urandom_range(0, 5)];
            else
                len = int'($urandom_range(1, 45));
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 3) == 0)
                    drv(int'($urandom_range(0, 4000)) - 500, 1'b0);
                drv(101 + int'($urandom_range(0, 3000)), 1'b1);
            end
        end
        repeat (4) drv(0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
